// File: rtl/dmem_ctrl.sv
// Byte-addressed data-memory controller with sub-word access and a fixed-latency handshake.
// Optional DMEM_CLEAR_ON_RESET_EN: zero the whole array after reset, one word per cycle.
module dmem_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int LATENCY   = 1,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic [1:0] ST_CLEAR = 2'd3;
  localparam logic [1:0] ST_RESET = ST_CLEAR;
`else
  localparam logic [1:0] ST_RESET = ST_IDLE;
`endif

  logic [31:0]       mem [0:DEPTH-1];
  logic [1:0]        state;
  logic [3:0]        lat_cnt;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic [3:0]        wr_be;
  logic [31:0]       wr_lanes;
  logic              misaligned;
  logic              accept;
  logic              wr_en;
  logic              sext;

  wire unused_addr_bits = &{1'b0, req_addr[31:ADDR_W+2]};

  assign word_idx   = req_addr[ADDR_W+1:2];
  assign rd_word    = mem[word_idx];
  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign accept     = (state == ST_IDLE) && req_valid;
  assign wr_en      = !reset && accept && req_we && !misaligned;

  // Right-align the addressed byte/half, then extend it to 32 bits.
  always_comb begin
    shifted  = rd_word >> {req_addr[1:0], 3'b000};
    sext     = 1'b0;
    load_val = rd_word;
    case (req_size)
      2'b00: begin
        sext     = ~req_unsigned & shifted[7];
        load_val = {{24{sext}}, shifted[7:0]};
      end
      2'b01: begin
        sext     = ~req_unsigned & shifted[15];
        load_val = {{16{sext}}, shifted[15:0]};
      end
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = req_wdata;
    case (req_size)
      2'b00: begin
        wr_be    = 4'b0001 << req_addr[1:0];
        wr_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        wr_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_wdata[15:0]}};
      end
      2'b10: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

`ifdef DMEM_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] clr_idx;
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
`ifdef DMEM_CLEAR_ON_RESET_EN
    else if (!reset && state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end
`endif
  end

  // The response is computed at the accept edge and held until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RESET;
      lat_cnt <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      clr_idx <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            rdata_q <= (misaligned || req_we) ? 32'h0 : load_val;
            err_q   <= misaligned;
            if (LATENCY <= 1) begin
              state <= ST_RESP;
            end else begin
              state   <= ST_WAIT;
              lat_cnt <= LAT_M1;
            end
          end
        end
        ST_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt <= 4'd1) state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
`ifdef DMEM_CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (&clr_idx) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table of single transactions plus stall and reset sequences.
module tb_dmem_ctrl;

  localparam int ADDR_W  = 6;
  localparam int LATENCY = 3;
  localparam int DEPTH   = 2 ** ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [28];

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response is consumed.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) checkOutput("accept_timeout", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) checkOutput("rsp_timeout", {31'b0, rsp_valid}, 32'd1);
    rdata = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          cnt;
    logic        seen;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'h0,        32'h0,        1'b0};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h13,  32'hABCDEF80, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,        32'h00000080, 1'b0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        32'h80000000, 1'b0};
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h110, 32'h0,        32'h80000000, 1'b0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h12,  32'h0,        32'hFFFF8000, 1'b0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h12,  32'h0,        32'h00008000, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h10,  32'h0,        32'h0,        1'b0};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h20,  32'h55667788, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 2'b01, 1'b0, 32'h22,  32'hBEEF1234, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        32'h00001234, 1'b0};
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h12347788, 1'b0};
    vecs[15] = '{1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        32'h00000077, 1'b0};
    vecs[16] = '{1'b0, 2'b10, 1'b1, 32'h20,  32'h0,        32'h12347788, 1'b0};
    vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h00,  32'h11223344, 32'h0,        1'b0};
    vecs[18] = '{1'b1, 2'b10, 1'b0, 32'h04,  32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h06,  32'h0,        32'h0,        1'b1};
    vecs[20] = '{1'b1, 2'b01, 1'b0, 32'h05,  32'h0000FFFF, 32'h0,        1'b1};
    vecs[21] = '{1'b1, 2'b11, 1'b0, 32'h00,  32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[22] = '{1'b0, 2'b11, 1'b0, 32'h04,  32'h0,        32'h0,        1'b1};
    vecs[23] = '{1'b0, 2'b10, 1'b0, 32'h04,  32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[24] = '{1'b0, 2'b10, 1'b0, 32'h00,  32'h0,        32'h11223344, 1'b0};
    vecs[25] = '{1'b1, 2'b00, 1'b0, 32'h22,  32'h0000005A, 32'h0,        1'b0};
    vecs[26] = '{1'b0, 2'b00, 1'b1, 32'h22,  32'h0,        32'h0000005A, 1'b0};
    vecs[27] = '{1'b0, 2'b10, 1'b0, 32'h20,  32'h0,        32'h125A7788, 1'b0};

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
`ifdef DMEM_CLEAR_ON_RESET_EN
    cnt = 0;
    while (!req_ready && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
`endif
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 28; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      checkOutput($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      checkOutput($sformatf("v%0d latency", i), lat, LATENCY);
    end

    // Consumer stalls for 5 cycles while the next request is already waiting.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h04;
    @(negedge clk);
    req_addr = 32'h00;
    cnt = 0;
    while (!rsp_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall%0d rsp_valid", k), {31'b0, rsp_valid}, 32'd1);
      checkOutput($sformatf("stall%0d rdata", k), rsp_rdata, 32'hA5A5A5A5);
      checkOutput($sformatf("stall%0d err", k), {31'b0, rsp_err}, 32'd0);
      checkOutput($sformatf("stall%0d req_ready", k), {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    checkOutput("stall_end rsp_valid", {31'b0, rsp_valid}, 32'd1);
    @(negedge clk);
    checkOutput("post_stall req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("post_stall rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("post_stall rdata", rsp_rdata, 32'h11223344);
    checkOutput("post_stall latency", lat, LATENCY);
    @(negedge clk);

    // Reset while a store is in WAIT: no response, store remains committed.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    cnt = 0;
    while (!req_ready && cnt < 400) begin
      seen = seen | rsp_valid;
      @(negedge clk);
      cnt++;
    end
    checkOutput("clear_cycles", cnt, DEPTH);
    checkOutput("midreset rsp_valid", {31'b0, seen}, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat);
    checkOutput("cleared word 0x30", rd, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checkOutput("cleared word 0x10", rd, 32'h0);
`else
    checkOutput("midreset req_ready", {31'b0, req_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      seen = seen | rsp_valid;
      @(negedge clk);
    end
    checkOutput("midreset rsp_valid", {31'b0, seen}, 32'd0);
    checkOutput("midreset depth", DEPTH, 64);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat);
    checkOutput("committed store 0x30", rd, 32'hCAFEF00D);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
